// File: rtl/agc_gain_ctl.sv
// Purpose: AGC sequencer; tracks frame peak |din|, requests gain = REF / peak from div16, holds the result.
// Latency: div_iv 2 cycles after frame_end; gain/gain_v 1 cycle after div_ov; abandons a request after TIMEOUT cycles.
// Backpressure: none on din (accumulation never stalls); one divide in flight, newer frame peak overwrites an unserviced one.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din, dv             signed sample stream and its valid strobe
//   div_a, div_b        divider numerator / denominator, stable while a request is in flight
//   div_iv              divider start pulse
//   div_q, div_ov       divider quotient and result-valid strobe
//   gain, gain_v        held gain and its one-cycle update strobe
//   frame_end           one-cycle strobe on the last sample of each frame
//   err                 sticky divider-timeout flag
module agc_gain_ctl #(
    parameter logic [15:0] REF        = 16'h4000,
    parameter int          FRAME_LOG2 = 8,
    parameter int          TIMEOUT    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        dv,
    output logic [15:0] div_a,
    output logic [15:0] div_b,
    output logic        div_iv,
    input  logic [15:0] div_q,
    input  logic        div_ov,
    output logic [15:0] gain,
    output logic        gain_v,
    output logic        frame_end,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state;
    logic [FRAME_LOG2-1:0] cnt;
    logic [15:0]           peak;
    logic [15:0]           pend_pk;
    logic                  pending;
    logic [TW-1:0]         timer;
    logic [15:0]           mag;
    logic [15:0]           cur_pk;
    logic                  cnt_last;

    // |din| as unsigned 15 bits; -32768 has no positive twin, so it saturates.
    always_comb begin
        mag = din;
        if (din == 16'h8000)
            mag = 16'h7fff;
        else if (din[15])
            mag = -din;
    end

    // Peak including the current sample; the first sample of a frame restarts it.
    always_comb begin
        cur_pk = mag;
        if (cnt != '0 && peak > mag)
            cur_pk = peak;
    end

    assign cnt_last  = &cnt;
    assign frame_end = dv & cnt_last;

    // Sample accumulation runs in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            peak    <= '0;
            pend_pk <= '0;
            pending <= 1'b0;
        end else begin
            if (dv) begin
                cnt  <= cnt + 1'b1;
                peak <= cur_pk;
                if (cnt_last)
                    pend_pk <= cur_pk;
            end
            // pending is consumed on the cycle pend_pk is sampled into div_b;
            // a frame ending that same cycle wins and keeps it set.
            if (frame_end)
                pending <= 1'b1;
            else if (state == IDLE && pending)
                pending <= 1'b0;
        end
    end

    // Request sequencer. Operands are loaded on the IDLE->REQ edge so they are
    // already valid in the div_iv cycle and stay put until the next request.
    // The timer starts at 0 in the div_iv cycle, so err rises TIMEOUT cycles after div_iv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            div_iv <= 1'b0;
            div_a  <= REF;
            div_b  <= 16'h0001;
            timer  <= '0;
            gain   <= REF;
            gain_v <= 1'b0;
            err    <= 1'b0;
        end else begin
            div_iv <= 1'b0;
            gain_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        div_iv <= 1'b1;
                        div_a  <= REF;
                        div_b  <= (pend_pk == 16'h0000) ? 16'h0001 : pend_pk;
                        timer  <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    timer <= timer + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_ov) begin
                        gain   <= div_q;
                        gain_v <= 1'b1;
                        state  <= IDLE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_agc_gain_ctl.sv
module tb_agc_gain_ctl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din   = 16'h0000;
    logic        dv    = 1'b0;
    logic [15:0] div_a, div_b, div_q, gain;
    logic        div_iv, div_ov, gain_v, frame_end, err;
    logic        div_en = 1'b1;

    agc_gain_ctl #(.REF(16'h4000), .FRAME_LOG2(2), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dv(dv),
        .div_a(div_a), .div_b(div_b), .div_iv(div_iv),
        .div_q(div_q), .div_ov(div_ov),
        .gain(gain), .gain_v(gain_v), .frame_end(frame_end), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: integer divide, result valid 17 cycles after the start pulse.
    logic [16:0] pv = '0;
    logic [15:0] pq [17];
    always @(posedge clk) begin
        pv    <= {pv[15:0], div_iv};
        pq[0] <= (div_b == 16'h0000) ? 16'hffff : div_a / div_b;
        for (int i = 1; i < 17; i++) pq[i] <= pq[i-1];
    end
    assign div_ov = pv[16] & div_en;
    assign div_q  = pq[16];

    int n_asrt = 0, n_fail = 0;
    int n_iv = 0, n_ov = 0, n_gv = 0;
    int iv_cyc = -100, ov_cyc = 0, fe_cyc = 0;
    logic [15:0] exp_b_q [$];
    logic [15:0] exp_g_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mag(input logic [15:0] x);
        if (x == 16'h8000) return 16'h7fff;
        return x[15] ? 16'(-x) : x;
    endfunction

    // Scoreboard side: every request and every gain update is compared against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (div_ov) begin
                n_ov++;
                ov_cyc = cyc;
            end
            if (div_iv) begin
                n_iv++;
                check("iv_spacing_ge_19", 32'(cyc - iv_cyc >= 19), 32'd1);
                iv_cyc = cyc;
                if (exp_b_q.size() == 0)
                    check("unexpected_div_iv", 32'd0, 32'd1);
                else begin
                    check("div_a", div_a, 32'h4000);
                    check("div_b", div_b, exp_b_q.pop_front());
                end
            end
            if (gain_v) begin
                n_gv++;
                check("gain_v_after_ov", cyc - ov_cyc, 32'd1);
                if (exp_g_q.size() == 0)
                    check("unexpected_gain_v", 32'd0, 32'd1);
                else
                    check("gain", gain, exp_g_q.pop_front());
            end
        end
    end

    // sel: 0 = div_iv, 1 = gain_v, 2 = err
    task automatic wait_for(input int sel, input int limit, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            hit = (sel == 0) ? div_iv : (sel == 1) ? gain_v : err;
        end
        check({tag, "_seen"}, 32'(hit), 32'd1);
    endtask

    // Drive one 4-sample frame; optionally push the expected request and gain.
    task automatic frame(input logic [15:0] s0, s1, s2, s3, input bit req, input bit want_g);
        logic [15:0] s [4];
        logic [15:0] pk, b;
        s  = '{s0, s1, s2, s3};
        pk = 16'h0000;
        for (int i = 0; i < 4; i++)
            if (mag(s[i]) > pk) pk = mag(s[i]);
        b = (pk == 16'h0000) ? 16'h0001 : pk;
        if (req) exp_b_q.push_back(b);
        if (want_g) exp_g_q.push_back(16'h4000 / b);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            din = s[i];
            dv  = 1'b1;
            @(negedge clk);
            check("frame_end", 32'(frame_end), 32'(i == 3));
            if (i == 3) fe_cyc = cyc;
        end
        @(posedge clk); #1;
        dv  = 1'b0;
        din = 16'h0000;
    endtask

    int t0, n0, g0, o0;

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gain", gain, 32'h4000);
        check("rst_gain_v", 32'(gain_v), 32'd0);
        check("rst_div_iv", 32'(div_iv), 32'd0);
        check("rst_div_a", div_a, 32'h4000);
        check("rst_div_b", div_b, 32'h0001);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_iv", n_iv, 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_gain", gain, 32'h4000);

        // Basic frame: peak 256 -> gain 64
        frame(16'd5, 16'hff00, 16'd100, 16'd7, 1'b1, 1'b1);
        wait_for(0, 10, "basic_iv");
        check("iv_latency", cyc - fe_cyc, 32'd2);
        wait_for(1, 30, "basic_gv");
        check("gv_after_iv", cyc - iv_cyc, 32'd18);
        repeat (3) @(negedge clk);
        check("basic_gain_held", gain, 32'd64);

        // Saturation: all -32768 -> div_b 32767, gain 0
        frame(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1);
        wait_for(0, 10, "sat_iv");
        wait_for(1, 30, "sat_gv");
        check("sat_gain", gain, 32'd0);

        // Zero frame: div_b clamped to 1, gain 0x4000
        frame(16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1);
        wait_for(0, 10, "zero_iv");
        wait_for(1, 30, "zero_gv");
        check("zero_gain", gain, 32'h4000);

        // Overlap: two frames end while the first request is in flight; only the latest is serviced
        n0 = n_iv;
        frame(16'h0100, 16'hfffb, 16'h0020, 16'd3, 1'b1, 1'b1);
        frame(16'h0180, 16'd1, 16'd2, 16'd3, 1'b0, 1'b0);
        frame(16'd1, 16'hfe00, 16'd2, 16'd3, 1'b1, 1'b1);
        wait_for(1, 40, "ovl_gv1");
        wait_for(1, 40, "ovl_gv2");
        repeat (30) @(negedge clk);
        check("ovl_req_count", n_iv - n0, 32'd2);
        check("ovl_gain", gain, 32'd32);

        // Timeout: divider never answers
        div_en = 1'b0;
        g0 = n_gv;
        frame(16'h0080, 16'd1, 16'd2, 16'd3, 1'b1, 1'b0);
        wait_for(0, 10, "to_iv");
        t0 = cyc;
        wait_for(2, 40, "to_err");
        check("to_err_delay", cyc - t0, 32'd32);
        check("to_gain_held", gain, 32'd32);
        check("to_no_gain_v", n_gv - g0, 32'd0);
        div_en = 1'b1;
        frame(16'h0040, 16'd1, 16'd2, 16'd3, 1'b1, 1'b1);
        wait_for(0, 10, "after_to_iv");
        wait_for(1, 30, "after_to_gv");
        check("after_to_gain", gain, 32'h0100);
        check("err_sticky", 32'(err), 32'd1);

        // Reset mid-WAIT; the stray result must be ignored
        frame(16'h0010, 16'd1, 16'd2, 16'd3, 1'b1, 1'b0);
        wait_for(0, 10, "rw_iv");
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rw_gain", gain, 32'h4000);
        check("rw_err", 32'(err), 32'd0);
        check("rw_div_iv", 32'(div_iv), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        g0 = n_gv;
        o0 = n_ov;
        repeat (20) @(negedge clk);
        check("rw_stray_ov_seen", n_ov - o0, 32'd1);
        check("rw_no_gain_v", n_gv - g0, 32'd0);
        check("rw_gain_after", gain, 32'h4000);

        check("exp_b_drained", exp_b_q.size(), 32'd0);
        check("exp_g_drained", exp_g_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/agc_gain_ctl.md
Name: agc_gain_ctl

Overview:
Automatic-gain-control sequencer that sits directly upstream and downstream of the 16-bit divider (div16). It tracks the peak magnitude of a sample stream over fixed-length frames. At each frame end it issues one division request, gain = REF / peak, to the divider. It captures the returned quotient into a held gain register for the downstream scaler. The divider has no ready/busy output, so this block alone enforces one-request-in-flight and recovers if no result returns.

Parameters:
REF, 16'h4000, numerator (target level) driven on div_a
FRAME_LOG2, 8, frame length = 2^FRAME_LOG2 valid samples
TIMEOUT, 32, max cycles from div_iv to div_ov before abandoning the request (must exceed divider latency of 17)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
din  in  16  signed two's-complement sample
dv  in  1  din valid strobe
div_a  out  16  divider numerator (ain)
div_b  out  16  divider denominator (bin)
div_iv  out  1  divider start pulse (iv)
div_q  in  16  divider quotient (qout)
div_ov  in  1  divider result valid (ov)
gain  out  16  current gain, held between updates
gain_v  out  1  one-cycle strobe when gain updates
frame_end  out  1  one-cycle strobe on last sample of each frame
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): gain=REF, gain_v=0, div_iv=0, div_a=REF, div_b=16'h0001, frame_end=0, err=0, peak=0, sample count=0, pending=0, FSM=IDLE. Release is sampled synchronously on the next clk edge. Reset mid-request abandons the request; any later div_ov is ignored until a new request is issued.
- Magnitude: mag = |din|, with -32768 saturating to 32767. Magnitude is unsigned 15 bits, zero-extended to 16.
- Peak and frame counting, on each dv=1:
  - Count increments modulo 2^FRAME_LOG2.
  - If count is 0 (first sample of a frame), peak <= mag; otherwise peak <= max(peak, mag).
  - When count = 2^FRAME_LOG2-1, frame_end pulses that cycle, and the frame peak (including the current sample) is latched into pend_pk with pending <= 1.
  - A newer frame peak overwrites an unserviced pend_pk; no queueing beyond depth 1.
- FSM states IDLE, REQ, WAIT:
  - IDLE: if pending=1, go to REQ.
  - REQ (one cycle): div_a <= REF; div_b <= max(pend_pk, 1), so zero is clamped to 1; div_iv=1 for exactly this cycle; pending <= 0 unless a new frame_end occurs the same cycle (new frame wins, so pending stays 1); timer cleared; go to WAIT.
  - WAIT: div_a and div_b are held stable; timer increments.
    - If div_ov=1: gain <= div_q, gain_v=1 next cycle, go to IDLE.
    - Else if timer = TIMEOUT-1: err <= 1, gain unchanged, go to IDLE.
  - div_ov outside WAIT is ignored.
- Throughput: at most one request in flight. Minimum request spacing is divider latency + 2 cycles. div_iv is never asserted in WAIT.
- Latency:
  - div_iv asserts 2 cycles after the frame_end cycle (IDLE->REQ, then REQ).
  - gain_v asserts 1 cycle after the div_ov cycle.
- Simultaneous events: dv continues to be processed in every FSM state, so sample accumulation never stalls.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then 20 idle cycles with dv=0 -> gain=16'h4000, div_iv never asserts, err=0.
- Basic frame (FRAME_LOG2=2, bench divider = integer divide with 17-cycle latency): din = 5, -256, 100, 7 -> frame_end on 4th sample; div_iv pulse with div_a=16'h4000, div_b=256; 17 cycles later div_ov; next cycle gain=64, gain_v=1.
- Saturation and zero: frame of all -32768 -> div_b=32767, gain=0. Frame of all 0 -> div_b=1, gain=16'h4000.
- Overlap: two frames end while WAIT is busy with the first, peaks 0x0100 then 0x0200 -> exactly one further request, with div_b=0x0200; gain sequence 64 then 32.
- Timeout (TIMEOUT=32): bench never returns div_ov -> err=1 exactly 32 cycles after div_iv, gain unchanged, next frame issues a new request.
- Reset mid-WAIT: assert rst_n low 5 cycles after div_iv, then let a stray div_ov arrive -> gain stays 16'h4000, gain_v stays 0.
